spi_byte_master: RTL and testbench
==================================

// Module: spi_byte_master
// PURPOSE
//   Byte-wide SPI mode-0 master engine; the stage directly below the bootloader.
//   Consumes data_tx/txn_start/force_clock and returns data_rx/txn_done.
//   Drives SCLK/MOSI and samples MISO. Chip-enables stay with the caller (flash/RAM select).
//   Also emits free-running dummy clocks on request, for device wake-up/init.
// PARAMETERS
//   CLK_DIV  2  clk cycles per SCLK half-period (>=1); SCLK = f_clk / (2*CLK_DIV)
// PORTS
//   clk          in   1  system clock; all logic on rising edge
//   rst          in   1  reset: synchronous, active-high
//   data_tx      in   8  byte to shift out, MSB first; latched on accepted start
//   txn_start    in   1  request one 8-bit transfer; accepted only when busy=0
//   force_clock  in   1  level: while high and idle, free-run SCLK with MOSI=1
//   data_rx      out  8  last received byte; stable from txn_done until next accept
//   txn_done     out  1  one-cycle pulse: transfer complete, data_rx valid
//   busy         out  1  high from accept edge until txn_done cycle (inclusive)
//   spi_sclk     out  1  SPI clock, idles low (CPOL=0)
//   spi_mosi     out  1  master out; changes only while SCLK low
//   spi_miso     in   1  master in; sampled on SCLK rising edge
// BEHAVIOUR
//   Reset values: data_rx=0, txn_done=0, busy=0, spi_sclk=0, spi_mosi=0; state IDLE.
//   States:
//     IDLE   - sclk=0.
//              txn_start & !force_clock -> latch data_tx into shift reg, bit_cnt=7, div=0;
//                busy=1, mosi=data_tx[7] -> LOW.
//              force_clock -> FORCE.
//     LOW    - sclk=0 for CLK_DIV cycles; then sclk->1, capture miso into shift LSB -> HIGH.
//     HIGH   - sclk=1 for CLK_DIV cycles; then sclk->0.
//              bit_cnt!=0: shift left, mosi=next bit, bit_cnt-- -> LOW.
//              bit_cnt==0: data_rx<=shift reg, txn_done=1 for 1 cycle -> IDLE.
//     FORCE  - toggle sclk every CLK_DIV cycles, mosi=1, nothing captured.
//              On force_clock low: finish the current high phase, leave sclk=0 -> IDLE.
//   Latency: txn_done is high in the cycle exactly 16*CLK_DIV clks after the accept edge.
//     For CLK_DIV=2 that is 32 clks. busy falls the cycle after txn_done.
//   Back-to-back: txn_start held high during the txn_done cycle is ignored (busy=1).
//     It is accepted on the next edge, so the inter-byte gap is 1 clk with sclk low.
//   Start while busy or in FORCE: ignored, no queuing.
//   Simultaneous txn_start & force_clock in IDLE: force_clock wins, start dropped.
//   Reset mid-transfer: immediate return to IDLE.
//     sclk=0, mosi=0, no txn_done pulse, data_rx cleared to 0.
//   data_tx changes after accept have no effect. mosi holds its last bit in IDLE.
//   Counters:
//     div: $clog2(CLK_DIV+1) bits, wraps to 0 at CLK_DIV-1.
//     bit_cnt: 3 bits, never wraps below 0.
// STRUCTURE
//   Shared package: state encoding localparams (IDLE/LOW/HIGH/FORCE).
//   Shared package: SPI_MODE0 constant and default divider, shared with the bootloader's SPI glue.
//   One natural sub-module: spi_clk_div, the half-period tick generator (CLK_DIV, enable, tick).
//   Everything else (FSM, shift reg, bit counter) stays flat in this module.
// TESTING
//   1. CLK_DIV=2, miso looped to mosi, start with data_tx=8'hA5:
//      8 sclk pulses, mosi bits 1,0,1,0,0,1,0,1; txn_done 32 clks after accept; data_rx=8'hA5.
//   2. miso tied 0, data_tx=8'hFF:
//      data_rx=8'h00, txn_done pulse exactly 1 cycle wide.
//      Pulse start during busy -> no extra transfer.
//   3. Start held high continuously, data_tx 8'h3C then 8'hC3:
//      two transfers separated by a 1-clk idle gap; busy low only in that gap.
//   4. force_clock high for 40 clks (CLK_DIV=2):
//      sclk toggles every 2 clks, mosi=1, no txn_done, data_rx unchanged; sclk low at exit.
//      Start + force in the same cycle -> FORCE only.
//   5. rst asserted at clk 10 of a transfer:
//      next cycle sclk=0, mosi=0, busy=0, data_rx=0, no txn_done.
//      A new start then completes normally.
//   6. CLK_DIV=1: data_tx=8'h5A looped back -> data_rx=8'h5A, txn_done 16 clks after accept.

Source files
------------

// File: rtl/spi_byte_master_pkg.sv
// Shared SPI definitions for the byte master and the bootloader's SPI glue.
package spi_byte_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_FORCE = 2'd3
    } spi_state_t;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam int SPI_DEFAULT_CLK_DIV = 2;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick is high in every CLK_DIV-th enabled cycle.
import spi_byte_master_pkg::*;

module spi_clk_div #(
    parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    assign tick = en && (div == DIV_LAST);

    // Held at zero while disabled so every phase starts a full half-period.
    always_ff @(posedge clk) begin
        if (rst || !en || tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/spi_byte_master.sv
// Byte-wide SPI mode-0 master: MSB-first shift, MISO sampled on SCLK rise,
// plus free-running dummy clocks (MOSI high) while force_clock is held.
import spi_byte_master_pkg::*;

module spi_byte_master #(
    parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_tx,
    input  logic       txn_start,
    input  logic       force_clock,
    output logic [7:0] data_rx,
    output logic       txn_done,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic SCLK_IDLE = SPI_MODE0[1];

    spi_state_t state, state_nxt;
    logic [7:0] shift_q, shift_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] rx_nxt;
    logic       sclk_nxt, mosi_nxt, done_nxt;
    logic       div_en, tick;

    assign div_en = (state != ST_IDLE);
    // The done cycle still counts as busy, which forces a one-clock gap between bytes.
    assign busy   = (state == ST_LOW) || (state == ST_HIGH) || txn_done;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .tick (tick)
    );

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        rx_nxt      = data_rx;
        sclk_nxt    = spi_sclk;
        mosi_nxt    = spi_mosi;
        done_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                sclk_nxt = SCLK_IDLE;
                if (force_clock) begin
                    mosi_nxt  = 1'b1;
                    state_nxt = ST_FORCE;
                end else if (txn_start && !txn_done) begin
                    shift_nxt   = data_tx;
                    bit_cnt_nxt = 3'd7;
                    mosi_nxt    = data_tx[7];
                    state_nxt   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    sclk_nxt  = 1'b1;
                    shift_nxt = {shift_q[6:0], spi_miso};
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                // After the rise-edge shift, shift_q[7] is already the next bit to send.
                if (tick) begin
                    sclk_nxt = SCLK_IDLE;
                    if (bit_cnt != 3'd0) begin
                        mosi_nxt    = shift_q[7];
                        bit_cnt_nxt = bit_cnt - 3'd1;
                        state_nxt   = ST_LOW;
                    end else begin
                        rx_nxt    = shift_q;
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_FORCE: begin
                mosi_nxt = 1'b1;
                if (!force_clock && (spi_sclk == SCLK_IDLE)) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    sclk_nxt = !spi_sclk;
                    if (!force_clock) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            data_rx  <= 8'h00;
            txn_done <= 1'b0;
            spi_sclk <= SCLK_IDLE;
            spi_mosi <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            data_rx  <= rx_nxt;
            txn_done <= done_nxt;
            spi_sclk <= sclk_nxt;
            spi_mosi <= mosi_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_nxt;
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: table-driven transfers with a scoreboard, plus
// back-to-back, force-clock, reset-abort and CLK_DIV=1 sequences.
module tb_spi_byte_master;

    localparam int DIV_A = 2;

    logic       clk;
    logic       rst;
    logic [7:0] data_tx;
    logic       txn_start;
    logic       force_clock;
    logic [7:0] data_rx_a;
    logic       txn_done_a, busy_a, sclk_a, mosi_a, miso_a;
    logic [1:0] miso_mode;

    logic [7:0] data_tx_b;
    logic       start_b;
    logic       force_b;
    logic [7:0] data_rx_b;
    logic       done_b, busy_b, sclk_b, mosi_b;

    spi_byte_master #(.CLK_DIV(DIV_A)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .data_tx     (data_tx),
        .txn_start   (txn_start),
        .force_clock (force_clock),
        .data_rx     (data_rx_a),
        .txn_done    (txn_done_a),
        .busy        (busy_a),
        .spi_sclk    (sclk_a),
        .spi_mosi    (mosi_a),
        .spi_miso    (miso_a)
    );

    spi_byte_master #(.CLK_DIV(1)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .data_tx     (data_tx_b),
        .txn_start   (start_b),
        .force_clock (force_b),
        .data_rx     (data_rx_b),
        .txn_done    (done_b),
        .busy        (busy_b),
        .spi_sclk    (sclk_b),
        .spi_mosi    (mosi_b),
        .spi_miso    (mosi_b)
    );

    // miso_mode: 0 = loopback from mosi, 1 = tied low, 2 = tied high
    always_comb begin
        miso_a = 1'b0;
        if (miso_mode == 2'd0) miso_a = mosi_a;
        else if (miso_mode == 2'd2) miso_a = 1'b1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_pushed = 0;
    int n_done = 0;
    int n_rise = 0;
    logic [7:0] seen_bits = 8'h00;
    logic prev_sclk = 1'b0;
    logic prev_done = 1'b0;

    // Scoreboard monitor: collects mosi at each sclk rise, checks each done pulse.
    always @(negedge clk) begin
        if (sclk_a && !prev_sclk) begin
            seen_bits = {seen_bits[6:0], mosi_a};
            n_rise++;
        end
        if (txn_done_a) begin
            n_done++;
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("data_rx", {24'd0, data_rx_a}, {24'd0, mon_e.rx});
                check("latency", 32'(cyc - mon_e.acc), 32'(16 * DIV_A));
                check("mosi_bits", {24'd0, seen_bits}, {24'd0, mon_e.tx});
                check("sclk_pulses", 32'(n_rise), 32'd8);
            end
            n_rise = 0;
        end
        prev_sclk = sclk_a;
        prev_done = txn_done_a;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] rx);
        data_tx   = tx;
        txn_start = 1'b1;
        n_rise    = 0;
        seen_bits = 8'h00;
        sb.push_back('{tx, rx, cyc + 1});
        n_pushed++;
        step();
        txn_start = 1'b0;
        data_tx   = ~tx;
    endtask

    task automatic wait_done(input int target);
        int i;
        for (i = 0; i < 200; i++) begin
            if (n_done >= target) break;
            step();
        end
        if (i == 200) check("wait_done_timeout", 32'(n_done), 32'(target));
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [1:0] mode;
        logic [7:0] rx;
    } vec_t;

    vec_t vecs[5];
    int   acc1, lows, e0, accb, done0, n_b;
    logic gap_sclk, flag_mosi, flag_busy, flag_done;

    initial begin
        vecs[0] = '{8'hA5, 2'd0, 8'hA5};
        vecs[1] = '{8'hFF, 2'd1, 8'h00};
        vecs[2] = '{8'h00, 2'd2, 8'hFF};
        vecs[3] = '{8'h3C, 2'd0, 8'h3C};
        vecs[4] = '{8'h81, 2'd1, 8'h00};

        rst = 1'b1; data_tx = 8'h00; txn_start = 1'b0; force_clock = 1'b0;
        miso_mode = 2'd0; data_tx_b = 8'h00; start_b = 1'b0; force_b = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_data_rx", {24'd0, data_rx_a}, 32'd0);
        check("rst_txn_done", {31'd0, txn_done_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_sclk", {31'd0, sclk_a}, 32'd0);
        check("rst_mosi", {31'd0, mosi_a}, 32'd0);

        // Table-driven transfers, each with a start pulse while busy that must be ignored.
        for (int v = 0; v < 5; v++) begin
            miso_mode = vecs[v].mode;
            start_xfer(vecs[v].tx, vecs[v].rx);
            repeat (9) step();
            check("busy_mid", {31'd0, busy_a}, 32'd1);
            data_tx   = 8'h5A;
            txn_start = 1'b1;
            step();
            txn_start = 1'b0;
            wait_done(n_pushed);
            repeat (3) step();
        end

        // Back-to-back with start held high: exactly one idle clock between bytes.
        miso_mode = 2'd0;
        acc1 = cyc + 1;
        data_tx = 8'h3C;
        txn_start = 1'b1;
        n_rise = 0;
        sb.push_back('{8'h3C, 8'h3C, acc1});
        sb.push_back('{8'hC3, 8'hC3, acc1 + 16 * DIV_A + 2});
        n_pushed += 2;
        step();
        data_tx = 8'hC3;
        lows = 0;
        gap_sclk = 1'b0;
        while (cyc < acc1 + 16 * DIV_A + 2) begin
            step();
            if (!busy_a) begin
                lows++;
                gap_sclk = gap_sclk | sclk_a;
            end
        end
        txn_start = 1'b0;
        check("b2b_gap_len", 32'(lows), 32'd1);
        check("b2b_gap_sclk", {31'd0, gap_sclk}, 32'd0);
        wait_done(n_pushed);
        repeat (3) step();

        // Force clock with a simultaneous start: start is dropped.
        miso_mode = 2'd1;
        done0 = n_done;
        data_tx = 8'h77;
        txn_start = 1'b1;
        force_clock = 1'b1;
        e0 = cyc + 1;
        step();
        txn_start = 1'b0;
        flag_mosi = 1'b0; flag_busy = 1'b0; flag_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            check("force_sclk", {31'd0, sclk_a}, 32'((k >> 1) & 1));
            flag_mosi = flag_mosi | !mosi_a;
            flag_busy = flag_busy | busy_a;
            flag_done = flag_done | txn_done_a;
            step();
        end
        force_clock = 1'b0;
        repeat (4) step();
        check("force_exit_sclk", {31'd0, sclk_a}, 32'd0);
        repeat (4) begin
            step();
            flag_busy = flag_busy | busy_a | sclk_a;
        end
        check("force_mosi_high", {31'd0, flag_mosi}, 32'd0);
        check("force_not_busy", {31'd0, flag_busy}, 32'd0);
        check("force_no_done", {31'd0, flag_done}, 32'd0);
        check("force_done_count", 32'(n_done), 32'(done0));
        check("force_data_rx", {24'd0, data_rx_a}, 32'h000000C3);

        // Reset ten clocks into a transfer while mosi is high.
        miso_mode = 2'd0;
        start_xfer(8'hE7, 8'hE7);
        repeat (9) step();
        check("pre_rst_mosi", {31'd0, mosi_a}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_sclk", {31'd0, sclk_a}, 32'd0);
        check("abort_mosi", {31'd0, mosi_a}, 32'd0);
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        check("abort_data_rx", {24'd0, data_rx_a}, 32'd0);
        check("abort_done", {31'd0, txn_done_a}, 32'd0);
        void'(sb.pop_back());
        n_pushed--;
        done0 = n_done;
        repeat (40) step();
        check("abort_no_done", 32'(n_done), 32'(done0));
        start_xfer(8'h69, 8'h69);
        wait_done(n_pushed);
        repeat (2) step();

        // CLK_DIV=1 instance, loopback.
        data_tx_b = 8'h5A;
        start_b = 1'b1;
        accb = cyc + 1;
        step();
        start_b = 1'b0;
        data_tx_b = 8'h00;
        n_b = 0;
        while (!done_b && n_b < 60) begin
            step();
            n_b++;
        end
        check("div1_latency", 32'(cyc - accb), 32'd16);
        check("div1_data_rx", {24'd0, data_rx_b}, 32'h0000005A);

        repeat (3) step();
        check("done_count", 32'(n_done), 32'(n_pushed));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
